// File: rtl/sid_voice_osc_if.sv
// Register-file side and oscillator side of one SID voice oscillator.
// Three of these chain via sync_out/msb_out into sync_in/ring_msb_in of the next voice.
interface sid_voice_osc_if #(
    parameter int ACC_W  = 24,
    parameter int FREQ_W = 16,
    parameter int OUT_W  = 12
);
    logic              clk_en;
    logic [FREQ_W-1:0] freq;
    logic [OUT_W-1:0]  pw;
    logic [3:0]        wave_sel;
    logic              test;
    logic              sync_en;
    logic              ring_en;
    logic              sync_in;
    logic              ring_msb_in;
    logic              sync_out;
    logic              msb_out;
    logic [ACC_W-1:0]  acc_out;
    logic [OUT_W-1:0]  wave_out;

    modport master (
        output clk_en, freq, pw, wave_sel, test, sync_en, ring_en, sync_in, ring_msb_in,
        input  sync_out, msb_out, acc_out, wave_out
    );

    modport slave (
        input  clk_en, freq, pw, wave_sel, test, sync_en, ring_en, sync_in, ring_msb_in,
        output sync_out, msb_out, acc_out, wave_out
    );
endinterface

// File: rtl/sid_voice_osc.sv
// SID-style voice oscillator: phase accumulator, 23-bit noise LFSR and a
// registered waveform mixer (saw/tri/pulse/noise, AND-combined), with hard sync and ring mod.
module sid_voice_osc #(
    parameter int ACC_W  = 24,
    parameter int FREQ_W = 16,
    parameter int OUT_W  = 12
) (
    input  logic             clk,
    input  logic             rst,
    sid_voice_osc_if.slave   osc
);
    localparam int MSB  = ACC_W - 1;
    localparam int NBIT = ACC_W - 5;

    logic [ACC_W-1:0] acc, acc_nxt;
    logic [22:0]      lfsr, lfsr_nxt;
    logic             sync_q, sync_nxt;
    logic [OUT_W-1:0] wave_q, wave_nxt;

    logic [OUT_W-1:0] saw_w, tri_w, pulse_w, noise_w;
    logic [OUT_W-2:0] tri_t;
    logic             tri_m;
    logic [7:0]       noise8;

    // Edge detection compares the current acc to the value about to be loaded, so
    // a forced zero (test or sync) can never look like a rising bit.
    always_comb begin
        acc_nxt  = acc;
        lfsr_nxt = lfsr;
        sync_nxt = 1'b0;
        if (osc.clk_en) begin
            if (osc.test)
                acc_nxt = '0;
            else if (osc.sync_en && osc.sync_in)
                acc_nxt = '0;
            else
                acc_nxt = acc + ACC_W'(osc.freq);

            sync_nxt = ~acc[MSB] & acc_nxt[MSB];

            if (osc.test)
                lfsr_nxt = 23'h7FFFFF;
            else if (~acc[NBIT] & acc_nxt[NBIT])
                lfsr_nxt = {lfsr[21:0], lfsr[22] ^ lfsr[17]};
        end
    end

    always_comb begin
        saw_w   = acc[MSB -: OUT_W];
        tri_m   = acc[MSB] ^ (osc.ring_en & osc.ring_msb_in);
        tri_t   = acc[ACC_W-2 -: OUT_W-1];
        tri_w   = {tri_m ? ~tri_t : tri_t, 1'b0};
        pulse_w = (osc.test || (saw_w >= osc.pw)) ? '1 : '0;
        noise8  = {lfsr[20], lfsr[18], lfsr[14], lfsr[11], lfsr[9], lfsr[5], lfsr[2], lfsr[0]};
        noise_w = OUT_W'(noise8) << (OUT_W - 8);

        wave_nxt = '1;
        if (osc.wave_sel[0]) wave_nxt = wave_nxt & tri_w;
        if (osc.wave_sel[1]) wave_nxt = wave_nxt & saw_w;
        if (osc.wave_sel[2]) wave_nxt = wave_nxt & pulse_w;
        if (osc.wave_sel[3]) wave_nxt = wave_nxt & noise_w;
        if (osc.wave_sel == 4'b0000) wave_nxt = '0;
    end

    // wave_out samples every clk so it trails the accumulator by exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            lfsr   <= 23'h7FFFFF;
            sync_q <= 1'b0;
            wave_q <= '0;
        end else begin
            acc    <= acc_nxt;
            lfsr   <= lfsr_nxt;
            sync_q <= sync_nxt;
            wave_q <= wave_nxt;
        end
    end

    assign osc.acc_out  = acc;
    assign osc.msb_out  = acc[MSB];
    assign osc.sync_out = sync_q;
    assign osc.wave_out = wave_q;
endmodule
